// File: rtl/srambank_ctrl_if.sv
// Client-side request/response channel for srambank_ctrl.
//   master : the datapath client (drives requests, accepts responses)
//   slave  : the bank controller (accepts requests, returns read data)
// Signals:
//   req_valid/req_ready  request handshake
//   req_write            1 = write, 0 = read
//   req_addr             {bank, word}; the upper BANK_W bits select the bank
//   req_wdata            write data
//   rsp_valid/rsp_ready  read-response handshake
//   rsp_rdata            read data
//   rsp_err              the read targeted a nonexistent bank
interface srambank_ctrl_if #(
    parameter int BANK_W = 2,
    parameter int ADDR_W = 9,
    parameter int DATA_W = 20
);
    logic                     req_valid;
    logic                     req_ready;
    logic                     req_write;
    logic [BANK_W+ADDR_W-1:0] req_addr;
    logic [DATA_W-1:0]        req_wdata;
    logic                     rsp_valid;
    logic                     rsp_ready;
    logic [DATA_W-1:0]        rsp_rdata;
    logic                     rsp_err;

    modport master (
        output req_valid, req_write, req_addr, req_wdata, rsp_ready,
        input  req_ready, rsp_valid, rsp_rdata, rsp_err
    );

    modport slave (
        input  req_valid, req_write, req_addr, req_wdata, rsp_ready,
        output req_ready, rsp_valid, rsp_rdata, rsp_err
    );
endinterface

// File: rtl/srambank_ctrl.sv
// Initiator-side controller for NBANKS synchronous single-port SRAM banks.
// Requests arrive on bus (valid/ready); the bank field is decoded into a
// one-hot bank select and address, write data and strobes are driven to the
// banks from registers. Reads return on the bus response channel.
// Ports:
//   clk           clock, rising edge
//   reset         asynchronous active-high reset
//   bus           srambank_ctrl_if.slave request/response channel
//   sram_address  registered word address (all banks)
//   sram_wd       registered write data (all banks)
//   sram_banksel  registered one-hot bank select
//   sram_read     registered read strobe
//   sram_write    registered write strobe
//   sram_dataout  concatenated bank outputs, bank i at [i*DATA_W +: DATA_W]
module srambank_ctrl #(
    parameter int NBANKS = 4,
    parameter int BANK_W = 2,
    parameter int ADDR_W = 9,
    parameter int DATA_W = 20
) (
    input  logic                     clk,
    input  logic                     reset,
    srambank_ctrl_if.slave           bus,
    output logic [ADDR_W-1:0]        sram_address,
    output logic [DATA_W-1:0]        sram_wd,
    output logic [NBANKS-1:0]        sram_banksel,
    output logic                     sram_read,
    output logic                     sram_write,
    input  logic [NBANKS*DATA_W-1:0] sram_dataout
);

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        RD_ISSUE = 2'd1,
        RD_RESP  = 2'd2
    } state_t;

    // One extra bit so NBANKS == 2**BANK_W is representable.
    localparam logic [BANK_W:0] NBANKS_W = (BANK_W+1)'(NBANKS);

    state_t              state_q;
    logic [ADDR_W-1:0]   addr_q;
    logic [DATA_W-1:0]   wd_q;
    logic [NBANKS-1:0]   banksel_q;
    logic                read_q;
    logic                write_q;
    logic                rsp_valid_q;
    logic                rsp_err_q;
    logic [BANK_W-1:0]   bank_q;
    logic                oor_q;

    logic [BANK_W-1:0]   req_bank;
    logic [ADDR_W-1:0]   req_word;
    logic                oor_d;
    logic [NBANKS-1:0]   banksel_d;
    logic                accept;
    logic [DATA_W-1:0]   rdata_mux;

    assign req_bank = bus.req_addr[ADDR_W +: BANK_W];
    assign req_word = bus.req_addr[ADDR_W-1:0];
    assign oor_d    = ({1'b0, req_bank} >= NBANKS_W);

    // Ready drops combinationally with reset so nothing is accepted while
    // the controller is held in reset.
    assign bus.req_ready = (state_q == IDLE) && !reset;
    assign accept        = bus.req_valid && bus.req_ready;

    // An out-of-range bank matches no index, so its select is all-zero.
    always_comb begin
        // NOTE: every always_comb output gets a default first so no path
        // leaves it unassigned and infers a latch.
        banksel_d = '0;
        for (int i = 0; i < NBANKS; i++) begin
            banksel_d[i] = (req_bank == BANK_W'(i));
        end
    end

    // The selected bank holds its output until its next read, and no other
    // read is issued before the response handshake, so this mux is stable
    // for the whole of RD_RESP.
    always_comb begin
        rdata_mux = '0;
        if (!rsp_err_q) begin
            for (int i = 0; i < NBANKS; i++) begin
                if (bank_q == BANK_W'(i)) begin
                    rdata_mux = sram_dataout[i*DATA_W +: DATA_W];
                end
            end
        end
    end

    // NOTE: asynchronous reset takes effect immediately, without a clock;
    // it discards any in-flight read, so no response follows a reset.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q     <= IDLE;
            addr_q      <= '0;
            wd_q        <= '0;
            banksel_q   <= '0;
            read_q      <= 1'b0;
            write_q     <= 1'b0;
            rsp_valid_q <= 1'b0;
            rsp_err_q   <= 1'b0;
            bank_q      <= '0;
            oor_q       <= 1'b0;
        end else begin
            // NOTE: non-blocking assignments so every register samples the
            // pre-edge values regardless of statement order.
            case (state_q)
                IDLE: begin
                    read_q    <= 1'b0;
                    write_q   <= 1'b0;
                    banksel_q <= '0;
                    if (accept) begin
                        addr_q    <= req_word;
                        wd_q      <= bus.req_wdata;
                        banksel_q <= banksel_d;
                        bank_q    <= req_bank;
                        oor_q     <= oor_d;
                        if (bus.req_write) begin
                            // A write to a missing bank is accepted and dropped.
                            write_q <= !oor_d;
                        end else begin
                            read_q  <= 1'b1;
                            state_q <= RD_ISSUE;
                        end
                    end
                end
                RD_ISSUE: begin
                    // The bank samples the read strobe at this edge.
                    read_q      <= 1'b0;
                    write_q     <= 1'b0;
                    banksel_q   <= '0;
                    rsp_valid_q <= 1'b1;
                    rsp_err_q   <= oor_q;
                    state_q     <= RD_RESP;
                end
                RD_RESP: begin
                    if (bus.rsp_ready) begin
                        rsp_valid_q <= 1'b0;
                        rsp_err_q   <= 1'b0;
                        state_q     <= IDLE;
                    end
                end
                default: begin
                    state_q <= IDLE;
                end
            endcase
        end
    end

    assign sram_address  = addr_q;
    assign sram_wd       = wd_q;
    assign sram_banksel  = banksel_q;
    assign sram_read     = read_q;
    assign sram_write    = write_q;
    assign bus.rsp_valid = rsp_valid_q;
    assign bus.rsp_err   = rsp_err_q;
    assign bus.rsp_rdata = rdata_mux;

endmodule
